// File: rtl/wb_arbiter.sv
// Write-back port arbiter: round-robin between the ALU (A) and load (B) producers
// for the register file's single write port, with a one-stage registered output.
module wb_arbiter #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      stall,
    input  logic                      a_valid,
    input  logic [REG_ADDR_WIDTH-1:0] a_addr,
    input  logic [CPU_WIDTH-1:0]      a_data,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [REG_ADDR_WIDTH-1:0] b_addr,
    input  logic [CPU_WIDTH-1:0]      b_data,
    output logic                      b_ready,
    output logic                      write_en,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [CPU_WIDTH-1:0]      write_data,
    output logic                      last_grant
);

    logic                      write_en_q, write_en_d;
    logic [REG_ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [CPU_WIDTH-1:0]      write_data_q, write_data_d;
    logic                      last_grant_q, last_grant_d;

    logic                      grant_a, grant_b, grant_any;
    logic [REG_ADDR_WIDTH-1:0] sel_addr;
    logic [CPU_WIDTH-1:0]      sel_data;

    // On a tie the port not named by last_grant wins; readies are held low in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rstn && !stall) begin
            if (a_valid && b_valid) begin
                if (last_grant_q) grant_a = 1'b1;
                else              grant_b = 1'b1;
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign grant_any = grant_a | grant_b;
    assign sel_addr  = grant_b ? b_addr : a_addr;
    assign sel_data  = grant_b ? b_data : a_data;

    // x0 writes are accepted but never reach the register file.
    always_comb begin
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        last_grant_d = last_grant_q;
        if (grant_any) begin
            write_en_d   = (sel_addr != '0);
            write_addr_d = sel_addr;
            write_data_d = sel_data;
            last_grant_d = grant_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            last_grant_q <= 1'b1;
        end else begin
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected writes, a monitor pops
// them whenever write_en is presented and mirrors them into a register file.
module tb_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic        write_en, last_grant;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int errors = 0;
    int checks = 0;
    wr_t exp_q[$];
    logic [31:0] rf [32];

    wb_arbiter #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic st);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        stall   = st;
    endtask

    // Check the hand-given grant, queue the write it should produce, then advance a cycle.
    task automatic gnt(input string nm, input logic ea, input logic eb, input bit push);
        #1;
        chk({nm, "_a_ready"}, {31'b0, a_ready}, {31'b0, ea});
        chk({nm, "_b_ready"}, {31'b0, b_ready}, {31'b0, eb});
        if (push) begin
            if (ea && a_addr != 5'd0) exp_q.push_back('{a_addr, a_data});
            if (eb && b_addr != 5'd0) exp_q.push_back('{b_addr, b_data});
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rstn && write_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, none expected",
                         write_addr, write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'b0, write_addr}, {27'b0, e.addr});
                chk("wr_data", write_data, e.data);
                rf[write_addr] = write_data;
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset with both ports requesting
        drive(1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_en",   {31'b0, write_en},   32'd0);
        chk("rst_write_addr", {27'b0, write_addr}, 32'd0);
        chk("rst_write_data", write_data,          32'd0);
        chk("rst_a_ready",    {31'b0, a_ready},    32'd0);
        chk("rst_b_ready",    {31'b0, b_ready},    32'd0);
        chk("rst_last_grant", {31'b0, last_grant}, 32'd1);
        rstn = 1'b1;

        // Tie round-robin: A, B, A, B with refreshed values after each grant
        gnt("tie0", 1, 0, 1);
        chk("tie0_last_grant", {31'b0, last_grant}, 32'd0);
        drive(1, 5'd3, 32'hA3, 1, 5'd2, 32'hB, 0);
        gnt("tie1", 0, 1, 1);
        drive(1, 5'd3, 32'hA3, 1, 5'd4, 32'hB4, 0);
        gnt("tie2", 1, 0, 1);
        drive(1, 5'd5, 32'hA5, 1, 5'd4, 32'hB4, 0);
        gnt("tie3", 0, 1, 1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        gnt("idle", 0, 0, 1);
        chk("idle_write_en",   {31'b0, write_en},   32'd0);
        chk("idle_last_grant", {31'b0, last_grant}, 32'd1);

        // Single port A
        drive(1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0, 0);
        gnt("single", 1, 0, 1);
        chk("single_last_grant", {31'b0, last_grant}, 32'd0);

        // x0 write accepted but suppressed
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0);
        gnt("x0", 0, 1, 1);
        chk("x0_write_en",   {31'b0, write_en},   32'd0);
        chk("x0_write_addr", {27'b0, write_addr}, 32'd0);
        chk("x0_write_data", write_data,          32'hFFFF_FFFF);
        chk("x0_last_grant", {31'b0, last_grant}, 32'd1);

        // Stall with a write in flight; release grants B the same cycle
        drive(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, 0);
        gnt("pre_stall", 1, 0, 1);
        drive(1, 5'd8, 32'h88, 1, 5'd7, 32'h77, 1);
        gnt("stall0", 0, 0, 1);
        chk("stall_drain_we", {31'b0, write_en}, 32'd0);
        gnt("stall1", 0, 0, 1);
        gnt("stall2", 0, 0, 1);
        chk("stall_hold_lg", {31'b0, last_grant}, 32'd0);
        stall = 1'b0;
        gnt("unstall", 0, 1, 1);
        drive(1, 5'd8, 32'h88, 0, 5'd0, 32'h0, 0);
        gnt("post_stall", 1, 0, 1);

        // Same-address collision: A first, B last, B's value persists
        drive(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0);
        gnt("set_lg", 0, 1, 1);
        drive(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0);
        gnt("coll0", 1, 0, 1);
        drive(0, 5'd0, 32'h0, 1, 5'd7, 32'h22, 0);
        gnt("coll1", 0, 1, 1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        gnt("coll_idle", 0, 0, 1);
        chk("coll_rf_x7", rf[7], 32'h22);
        chk("rf_x5",      rf[5], 32'h1234_5678);

        // Reset mid-operation discards the buffered write
        drive(1, 5'd10, 32'hAA, 0, 5'd0, 32'h0, 0);
        gnt("pre_rst", 1, 0, 0);
        rstn = 1'b0;
        #1;
        chk("midrst_write_en",   {31'b0, write_en},   32'd0);
        chk("midrst_write_addr", {27'b0, write_addr}, 32'd0);
        chk("midrst_last_grant", {31'b0, last_grant}, 32'd1);
        chk("midrst_a_ready",    {31'b0, a_ready},    32'd0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rf_x10_untouched", rf[10], 32'h0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
